// File: rtl/ppd_input_commutator.sv
// Input commutator for the polyphase decimator: deals high-rate samples round-robin
// onto the branch shift registers, flags completed frames and reports when every branch is filled.
module ppd_input_commutator #(
   parameter int gp_data_width        = 8,
   parameter int gp_nr_phases         = 4,
   parameter int gp_nr_taps_per_phase = 4
) (
   input  logic                              i_rst_an,
   input  logic                              i_clk,
   input  logic                              i_ena,
   input  logic                              i_sync,
   input  logic [gp_data_width-1:0]          i_data,
   output logic [gp_data_width-1:0]          o_data,
   output logic [gp_nr_phases-1:0]           o_phase_ena,
   output logic [$clog2(gp_nr_phases)-1:0]   o_phase,
   output logic                              o_frame_done,
   output logic                              o_primed
);

   localparam int LP_PW = $clog2(gp_nr_phases);
   localparam int LP_FW = $clog2(gp_nr_taps_per_phase + 1);
   localparam logic [LP_PW-1:0]        LP_LAST = LP_PW'(gp_nr_phases - 1);
   localparam logic [LP_FW-1:0]        LP_TAPS = LP_FW'(gp_nr_taps_per_phase);
   localparam logic [gp_nr_phases-1:0] LP_ONE  = gp_nr_phases'(1);

   logic [LP_PW-1:0] r_phase;
   logic [LP_FW-1:0] r_frm;
   logic             w_wrap;
   logic [LP_PW-1:0] w_phase_nxt;
   logic             w_last_frame;

   // Branches are filled from the highest index down, so branch 0 closes a frame.
   assign w_wrap       = (r_phase == '0);
   assign w_phase_nxt  = w_wrap ? LP_LAST : (r_phase - LP_PW'(1));
   assign w_last_frame = (r_frm >= (LP_TAPS - LP_FW'(1)));

   always_ff @(posedge i_clk or negedge i_rst_an) begin
      if (!i_rst_an) begin
         r_phase      <= LP_LAST;
         r_frm        <= '0;
         o_data       <= '0;
         o_phase      <= '0;
         o_phase_ena  <= '0;
         o_frame_done <= 1'b0;
         o_primed     <= 1'b0;
      end else begin
         o_phase_ena  <= '0;
         o_frame_done <= 1'b0;
         if (i_sync) begin
            // Realign: the sync sample (if any) becomes the first of a fresh frame.
            r_frm    <= '0;
            o_primed <= 1'b0;
            if (i_ena) begin
               o_data      <= i_data;
               o_phase     <= LP_LAST;
               o_phase_ena <= LP_ONE << LP_LAST;
               r_phase     <= LP_LAST - LP_PW'(1);
            end else begin
               r_phase <= LP_LAST;
            end
         end else if (i_ena) begin
            o_data       <= i_data;
            o_phase      <= r_phase;
            o_phase_ena  <= LP_ONE << r_phase;
            o_frame_done <= w_wrap;
            r_phase      <= w_phase_nxt;
            if (w_wrap) begin
               if (r_frm != LP_TAPS) begin
                  r_frm <= r_frm + LP_FW'(1);
               end
               if (w_last_frame) begin
                  o_primed <= 1'b1;
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_ppd_input_commutator.sv
// Self-checking bench for ppd_input_commutator (M = 4, 3 taps per phase) using
// vector tables, directed corner sequences and a sample-count reference model.
module tb_ppd_input_commutator;

   localparam int M = 4;
   localparam int T = 3;

   logic       i_rst_an;
   logic       i_clk;
   logic       i_ena;
   logic       i_sync;
   logic [7:0] i_data;
   logic [7:0] o_data;
   logic [3:0] o_phase_ena;
   logic [1:0] o_phase;
   logic       o_frame_done;
   logic       o_primed;

   ppd_input_commutator #(
      .gp_data_width        (8),
      .gp_nr_phases         (M),
      .gp_nr_taps_per_phase (T)
   ) dut (
      .i_rst_an     (i_rst_an),
      .i_clk        (i_clk),
      .i_ena        (i_ena),
      .i_sync       (i_sync),
      .i_data       (i_data),
      .o_data       (o_data),
      .o_phase_ena  (o_phase_ena),
      .o_phase      (o_phase),
      .o_frame_done (o_frame_done),
      .o_primed     (o_primed)
   );

   initial i_clk = 1'b0;
   always #5 i_clk = ~i_clk;

   typedef struct {
      logic       ena;
      logic       sync;
      logic [7:0] data;
      logic [1:0] phase;
      logic [3:0] phEna;
      logic       fd;
      logic       primed;
   } vec_t;

   vec_t vecs [8];

   int nChecks = 0;
   int nErrors = 0;

   // Reference model: everything follows from the count of samples accepted since the last realign.
   int         mAcc;
   logic [7:0] mData;
   logic [1:0] mPhase;
   logic [3:0] mPhEna;
   logic       mFd;
   logic       mPrimed;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      nChecks++;
      if (act !== exp) begin
         nErrors++;
         $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic modelReset();
      mAcc    = 0;
      mData   = '0;
      mPhase  = '0;
      mPhEna  = '0;
      mFd     = 1'b0;
      mPrimed = 1'b0;
   endtask

   task automatic checkModel();
      checkOutput("data",      32'(o_data),       32'(mData));
      checkOutput("phase",     32'(o_phase),      32'(mPhase));
      checkOutput("phaseEna",  32'(o_phase_ena),  32'(mPhEna));
      checkOutput("frameDone", 32'(o_frame_done), 32'(mFd));
      checkOutput("primed",    32'(o_primed),     32'(mPrimed));
   endtask

   task automatic applyStimulus(input logic ena, input logic sync, input logic [7:0] data);
      i_ena  = ena;
      i_sync = sync;
      i_data = data;
      @(posedge i_clk);
      #1;
      mPhEna = '0;
      mFd    = 1'b0;
      if (sync) begin
         mAcc    = 0;
         mPrimed = 1'b0;
      end
      if (ena) begin
         mData  = data;
         mPhase = 2'(M - 1 - (mAcc % M));
         mPhEna = 4'(1) << mPhase;
         mFd    = ((mAcc % M) == M - 1);
         mAcc++;
         if ((mAcc / M) >= T) mPrimed = 1'b1;
      end
      i_ena  = 1'b0;
      i_sync = 1'b0;
      checkModel();
   endtask

   task automatic checkCleared(input string tag);
      checkOutput({tag, "Data"},   32'(o_data),       32'd0);
      checkOutput({tag, "PhEna"},  32'(o_phase_ena),  32'd0);
      checkOutput({tag, "Phase"},  32'(o_phase),      32'd0);
      checkOutput({tag, "Fd"},     32'(o_frame_done), 32'd0);
      checkOutput({tag, "Primed"}, 32'(o_primed),     32'd0);
   endtask

   task automatic doReset();
      i_rst_an = 1'b0;
      for (int k = 0; k < 3; k++) begin
         i_ena  = k[0];
         i_data = 8'(8'hA0 + k);
         @(posedge i_clk);
         #1;
         checkCleared("rst");
      end
      i_ena    = 1'b0;
      i_rst_an = 1'b1;
      modelReset();
   endtask

   initial begin
      vecs[0] = '{1'b1, 1'b0, 8'd1, 2'd3, 4'b1000, 1'b0, 1'b0};
      vecs[1] = '{1'b1, 1'b0, 8'd2, 2'd2, 4'b0100, 1'b0, 1'b0};
      vecs[2] = '{1'b1, 1'b0, 8'd3, 2'd1, 4'b0010, 1'b0, 1'b0};
      vecs[3] = '{1'b1, 1'b0, 8'd4, 2'd0, 4'b0001, 1'b1, 1'b0};
      vecs[4] = '{1'b1, 1'b0, 8'd5, 2'd3, 4'b1000, 1'b0, 1'b0};
      vecs[5] = '{1'b1, 1'b0, 8'd6, 2'd2, 4'b0100, 1'b0, 1'b0};
      vecs[6] = '{1'b1, 1'b0, 8'd7, 2'd1, 4'b0010, 1'b0, 1'b0};
      vecs[7] = '{1'b1, 1'b0, 8'd8, 2'd0, 4'b0001, 1'b1, 1'b0};

      i_rst_an = 1'b0;
      i_ena    = 1'b0;
      i_sync   = 1'b0;
      i_data   = '0;
      modelReset();
      #2;

      $display("[TB] reset with toggling enable");
      doReset();

      $display("[TB] continuous stream table");
      for (int k = 0; k < 8; k++) begin
         applyStimulus(vecs[k].ena, vecs[k].sync, vecs[k].data);
         checkOutput("tblData",   32'(o_data),       32'(vecs[k].data));
         checkOutput("tblPhase",  32'(o_phase),      32'(vecs[k].phase));
         checkOutput("tblPhEna",  32'(o_phase_ena),  32'(vecs[k].phEna));
         checkOutput("tblFd",     32'(o_frame_done), 32'(vecs[k].fd));
         checkOutput("tblPrimed", 32'(o_primed),     32'(vecs[k].primed));
      end

      $display("[TB] gapped stream");
      for (int k = 0; k < 8; k++) begin
         applyStimulus(1'b1, 1'b0, 8'(k + 1));
         checkOutput("gapPhase", 32'(o_phase), 32'(vecs[k].phase));
         applyStimulus(1'b0, 1'b0, 8'hEE);
         checkOutput("gapHold", 32'(o_data), 32'(k + 1));
         applyStimulus(1'b0, 1'b0, 8'hDD);
      end

      $display("[TB] priming after fresh reset");
      doReset();
      for (int k = 1; k <= 16; k++) begin
         applyStimulus(1'b1, 1'b0, 8'(k));
         if (k == 11) checkOutput("primedEarly", 32'(o_primed), 32'd0);
         if (k == 12) begin
            checkOutput("primedRise", 32'(o_primed),     32'd1);
            checkOutput("primedFd",   32'(o_frame_done), 32'd1);
         end
      end
      checkOutput("primedSticky", 32'(o_primed), 32'd1);

      $display("[TB] sync realign");
      applyStimulus(1'b1, 1'b0, 8'd17);
      applyStimulus(1'b1, 1'b0, 8'd18);
      applyStimulus(1'b1, 1'b1, 8'h55);
      checkOutput("syncData",   32'(o_data),      32'h55);
      checkOutput("syncPhase",  32'(o_phase),     32'd3);
      checkOutput("syncPhEna",  32'(o_phase_ena), 32'b1000);
      checkOutput("syncPrimed", 32'(o_primed),    32'd0);
      applyStimulus(1'b1, 1'b0, 8'd20);
      applyStimulus(1'b1, 1'b0, 8'd21);
      checkOutput("syncNoFd", 32'(o_frame_done), 32'd0);
      applyStimulus(1'b1, 1'b0, 8'd22);
      checkOutput("syncFd", 32'(o_frame_done), 32'd1);
      applyStimulus(1'b0, 1'b1, 8'h00);
      applyStimulus(1'b1, 1'b0, 8'd23);
      checkOutput("syncIdlePhase", 32'(o_phase), 32'd3);

      $display("[TB] asynchronous reset mid-frame");
      applyStimulus(1'b1, 1'b0, 8'd24);
      #2;
      i_rst_an = 1'b0;
      #2;
      checkCleared("async");
      #2;
      i_rst_an = 1'b1;
      modelReset();
      applyStimulus(1'b1, 1'b0, 8'd30);
      checkOutput("asyncFirstPhase", 32'(o_phase), 32'd3);
      for (int k = 2; k <= 12; k++) begin
         applyStimulus(1'b1, 1'b0, 8'(29 + k));
         if (k == 11) checkOutput("asyncPrimedEarly", 32'(o_primed), 32'd0);
      end
      checkOutput("asyncPrimed", 32'(o_primed), 32'd1);

      $display("[TB] randomized stimulus");
      for (int k = 0; k < 500; k++) begin
         applyStimulus(($urandom_range(0, 9) < 6), ($urandom_range(0, 39) == 0), 8'($urandom));
      end

      $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
      $finish;
   end

endmodule
